mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-port synchronous memory between the instruction-fetch path (addressed by the PC) and the load/store path. Grants at most one access per cycle, with load/store priority and a starvation guard for fetch. Tracks in-flight reads through a fixed-latency tag pipeline and routes read data back to the originating requester. FLUSH discards fetch responses made stale by a taken branch or jump.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- MEM_LAT, 1, memory read latency in cycles, legal range 1..4
- STARVE_MAX, 4, consecutive denied fetch cycles before fetch is forced to win, legal range 1..15

- CLK  in  1  clock, all state updates on rising edge
- RESET_N  in  1  reset, asynchronous assert, active-low
- IF_REQ  in  1  fetch read request
- IF_ADDR  in  ADDR_W  fetch address
- IF_GNT  out  1  fetch request accepted this cycle
- IF_RVALID  out  1  fetch read data valid
- IF_RDATA  out  DATA_W  fetch read data
- LS_REQ  in  1  load/store request
- LS_WE  in  1  1 = store, 0 = load
- LS_BE  in  DATA_W/8  store byte enables
- LS_ADDR  in  ADDR_W  load/store address
- LS_WDATA  in  DATA_W  store data
- LS_GNT  out  1  load/store request accepted this cycle
- LS_RVALID  out  1  load data valid
- LS_RDATA  out  DATA_W  load data
- FLUSH  in  1  kill all in-flight fetch reads; block fetch grant this cycle
- MEM_EN  out  1  memory access this cycle
- MEM_WE  out  1  memory write
- MEM_BE  out  DATA_W/8  memory byte enables
- MEM_ADDR  out  ADDR_W  memory address
- MEM_WDATA  out  DATA_W  memory write data
- MEM_RDATA  in  DATA_W  memory read data, valid MEM_LAT cycles after a read is issued

## Operation
- Grant logic is combinational. A request is accepted in the cycle its REQ is high and its GNT is high. No request-hold protocol: a requester that is not granted re-presents its request.
- Fetch eligibility: fetch is eligible when IF_REQ=1 and FLUSH=0.
- Default priority: LS_GNT = LS_REQ & ~force_if. IF_GNT = eligible & ~LS_GNT.
- force_if is 1 when starve_cnt == STARVE_MAX and fetch is eligible.
- starve_cnt:
  - saturating counter, reset 0
  - increments when fetch is eligible and not granted
  - clears when IF_GNT=1, IF_REQ=0, or FLUSH=1
- Memory port driven from the winner:
  - MEM_EN = IF_GNT | LS_GNT
  - fetch winner: MEM_WE=0, MEM_BE=all ones
  - load/store winner: MEM_WE=LS_WE, MEM_BE=LS_BE
  - ADDR and WDATA come from the winner
  - with no grant, MEM_EN=0 and all other MEM outputs are 0
- Tag pipeline: MEM_LAT stages, each holding {valid, src}. Stage 0 loads valid = MEM_EN & ~MEM_WE and src = IF_GNT. Stages shift every cycle.
- Response routing at the last stage:
  - valid & src=IF -> IF_RVALID=1, IF_RDATA=MEM_RDATA
  - valid & src=LS -> LS_RVALID=1, LS_RDATA=MEM_RDATA
  - RDATA is 0 whenever the matching RVALID is 0
- Stores produce no response.
- FLUSH=1 at an edge clears the valid bit of every stage with src=IF, including stage 0. Load entries are unaffected.
- While RESET_N=0: all GNT, MEM_EN, RVALID, RDATA and MEM outputs are forced to 0.

## Timing
- Reset values: IF_GNT=0, LS_GNT=0, IF_RVALID=0, LS_RVALID=0, IF_RDATA=0, LS_RDATA=0, MEM_EN=0, MEM_WE=0, MEM_BE=0, MEM_ADDR=0, MEM_WDATA=0. starve_cnt=0 and all tag stages invalid.
- Reset asserted mid-operation: all in-flight responses are discarded immediately. No RVALID appears after release for reads issued before reset.
- Grant latency: 0 cycles (same cycle as REQ).
- Read response: a read granted in cycle t returns RVALID in cycle t+MEM_LAT.
- Throughput: one access per cycle, back-to-back, any mix of sources. Responses return in issue order.
- Fairness under continuous contention: the grant pattern is STARVE_MAX load/store grants, then 1 fetch grant, repeating.
- FLUSH in the same cycle as a fetch request: no IF_GNT, no memory access for fetch. LS may still be granted that cycle.
- FLUSH in the same cycle as a fetch response: that IF_RVALID is still delivered, because the response is already at the output. Only stages that would return in later cycles are killed.

## Test plan
- MEM_LAT=2, fetch only. IF_REQ=1 with IF_ADDR=0x100 in cycle 0 -> IF_GNT=1, MEM_EN=1, MEM_ADDR=0x100, MEM_WE=0 in cycle 0. IF_RVALID=1 with IF_RDATA=MEM_RDATA in cycle 2, and 0 in other cycles.
- STARVE_MAX=4, IF_REQ and LS_REQ held high for 15 cycles -> LS_GNT in cycles 0-3, IF_GNT in cycle 4, LS in 5-8, IF in 9, LS in 10-13, IF in 14. Exactly one GNT per cycle.
- Store: LS_REQ=1, LS_WE=1, LS_BE=0011, LS_ADDR=0x40, LS_WDATA=0xDEADBEEF -> MEM_WE=1, MEM_BE=0011, MEM_WDATA=0xDEADBEEF. No LS_RVALID in the following MEM_LAT+2 cycles.
- MEM_LAT=3, fetch reads in cycles 0 and 1, load in cycle 2, FLUSH=1 in cycle 2 -> no IF_RVALID in cycles 3-4. LS_RVALID=1 in cycle 5. starve_cnt=0 after cycle 2.
- MEM_LAT=1, alternating LS load and IF fetch grants for 6 cycles, with MEM_RDATA = cycle number -> each RVALID arrives one cycle after its grant on the correct source, with the matching data. The non-responding RDATA is 0.
- Reads in flight, RESET_N pulled low between edges -> all outputs 0 immediately. After release, no RVALID until new grants are made, and starve_cnt restarts from 0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the arbiter and the
// single-port memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  IF_REQ;
  logic [ADDR_W-1:0]     IF_ADDR;
  logic                  IF_GNT;
  logic                  IF_RVALID;
  logic [DATA_W-1:0]     IF_RDATA;
  logic                  LS_REQ;
  logic                  LS_WE;
  logic [DATA_W/8-1:0]   LS_BE;
  logic [ADDR_W-1:0]     LS_ADDR;
  logic [DATA_W-1:0]     LS_WDATA;
  logic                  LS_GNT;
  logic                  LS_RVALID;
  logic [DATA_W-1:0]     LS_RDATA;
  logic                  FLUSH;
  logic                  MEM_EN;
  logic                  MEM_WE;
  logic [DATA_W/8-1:0]   MEM_BE;
  logic [ADDR_W-1:0]     MEM_ADDR;
  logic [DATA_W-1:0]     MEM_WDATA;
  logic [DATA_W-1:0]     MEM_RDATA;

  modport slave (
    input  IF_REQ, IF_ADDR, LS_REQ, LS_WE, LS_BE, LS_ADDR, LS_WDATA, FLUSH, MEM_RDATA,
    output IF_GNT, IF_RVALID, IF_RDATA, LS_GNT, LS_RVALID, LS_RDATA,
           MEM_EN, MEM_WE, MEM_BE, MEM_ADDR, MEM_WDATA
  );

  modport master (
    output IF_REQ, IF_ADDR, LS_REQ, LS_WE, LS_BE, LS_ADDR, LS_WDATA, FLUSH, MEM_RDATA,
    input  IF_GNT, IF_RVALID, IF_RDATA, LS_GNT, LS_RVALID, LS_RDATA,
           MEM_EN, MEM_WE, MEM_BE, MEM_ADDR, MEM_WDATA
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: load/store priority with a fetch starvation
// guard, fixed-latency read tag pipeline and fetch flush.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input logic                CLK,
  input logic                RESET_N,
  mem_port_arbiter_if.slave  bus
);

  logic [3:0]         starve_cnt;
  logic               if_elig;
  logic               force_if;
  logic               if_gnt;
  logic               ls_gnt;
  logic               mem_en;
  logic               mem_we;
  logic [MEM_LAT-1:0] vld_p;
  logic [MEM_LAT-1:0] src_p;
  logic               rsp_if;
  logic               rsp_ls;

  always_comb begin
    if_elig  = bus.IF_REQ & ~bus.FLUSH;
    force_if = if_elig & (starve_cnt == 4'(STARVE_MAX));
    ls_gnt   = bus.LS_REQ & ~force_if;
    if_gnt   = if_elig & ~ls_gnt;
    mem_en   = if_gnt | ls_gnt;
    mem_we   = ls_gnt & bus.LS_WE;
  end

  // Every output is held at zero while reset is asserted, independent of state.
  always_comb begin
    bus.IF_GNT    = RESET_N & if_gnt;
    bus.LS_GNT    = RESET_N & ls_gnt;
    bus.MEM_EN    = RESET_N & mem_en;
    bus.MEM_WE    = 1'b0;
    bus.MEM_BE    = '0;
    bus.MEM_ADDR  = '0;
    bus.MEM_WDATA = '0;
    if (RESET_N && ls_gnt) begin
      bus.MEM_WE    = bus.LS_WE;
      bus.MEM_BE    = bus.LS_BE;
      bus.MEM_ADDR  = bus.LS_ADDR;
      bus.MEM_WDATA = bus.LS_WDATA;
    end else if (RESET_N && if_gnt) begin
      bus.MEM_BE    = '1;
      bus.MEM_ADDR  = bus.IF_ADDR;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)
      starve_cnt <= '0;
    else if (if_gnt || !bus.IF_REQ || bus.FLUSH)
      starve_cnt <= '0;
    else if (starve_cnt != 4'hF)
      starve_cnt <= starve_cnt + 4'd1;
  end

  // Stage boundary: tag stage 0 captures the grant, later stages shift toward the
  // response port; a flush drops fetch tags still travelling through the pipe.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      vld_p <= '0;
      src_p <= '0;
    end else begin
      vld_p[0] <= mem_en & ~mem_we & ~(bus.FLUSH & if_gnt);
      src_p[0] <= if_gnt;
      for (int i = 1; i < MEM_LAT; i++) begin
        vld_p[i] <= vld_p[i-1] & ~(bus.FLUSH & src_p[i-1]);
        src_p[i] <= src_p[i-1];
      end
    end
  end

  // Stage boundary: the last tag stage lines up with MEM_RDATA.
  always_comb begin
    rsp_if         = RESET_N & vld_p[MEM_LAT-1] & src_p[MEM_LAT-1];
    rsp_ls         = RESET_N & vld_p[MEM_LAT-1] & ~src_p[MEM_LAT-1];
    bus.IF_RVALID  = rsp_if;
    bus.LS_RVALID  = rsp_ls;
    bus.IF_RDATA   = rsp_if ? bus.MEM_RDATA : '0;
    bus.LS_RDATA   = rsp_ls ? bus.MEM_RDATA : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: three arbiters (MEM_LAT 1, 2, 3) share one directed stimulus
// stream; expected grants are checked per cycle and expected responses queued.
module tb_mem_port_arbiter;

  localparam int G_NONE = 0;
  localparam int G_IF   = 1;
  localparam int G_LS   = 2;

  typedef struct {
    logic        src;
    int          due;
    logic [31:0] data;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b1;
  logic        run = 1'b0;
  logic        rel_pending = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          lat [3] = '{1, 2, 3};
  exp_t        q [3][$];

  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [3:0]  ls_be = '0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic        flush = 1'b0;
  logic [31:0] mem_rdata;

  logic [71:0] port_vec [3];
  logic [65:0] rsp_vec [3];

  function automatic logic [31:0] mdata(input int c);
    return {16'hA5A5, c[15:0]};
  endfunction

  assign mem_rdata = mdata(cyc);

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  mem_port_arbiter_if bus [3] ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4))
    u_lat1 (.CLK(CLK), .RESET_N(RESET_N), .bus(bus[0]));
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4))
    u_lat2 (.CLK(CLK), .RESET_N(RESET_N), .bus(bus[1]));
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4))
    u_lat3 (.CLK(CLK), .RESET_N(RESET_N), .bus(bus[2]));

  task automatic mon(input int k, input logic [65:0] r);
    exp_t        e;
    logic [65:0] want;
    want = '0;
    if (q[k].size() != 0 && q[k][0].due == cyc) begin
      e = q[k].pop_front();
      want = e.src ? {1'b1, e.data, 1'b0, 32'h0} : {1'b0, 32'h0, 1'b1, e.data};
    end
    checks++;
    if (r !== want) begin
      failures++;
      $display("FAIL rsp lat=%0d cyc=%0d got=%h want=%h", lat[k], cyc, r, want);
    end
  endtask

  for (genvar k = 0; k < 3; k++) begin : g_conn
    assign bus[k].IF_REQ    = if_req;
    assign bus[k].IF_ADDR   = if_addr;
    assign bus[k].LS_REQ    = ls_req;
    assign bus[k].LS_WE     = ls_we;
    assign bus[k].LS_BE     = ls_be;
    assign bus[k].LS_ADDR   = ls_addr;
    assign bus[k].LS_WDATA  = ls_wdata;
    assign bus[k].FLUSH     = flush;
    assign bus[k].MEM_RDATA = mem_rdata;
    assign port_vec[k] = {bus[k].IF_GNT, bus[k].LS_GNT, bus[k].MEM_EN, bus[k].MEM_WE,
                          bus[k].MEM_BE, bus[k].MEM_ADDR, bus[k].MEM_WDATA};
    assign rsp_vec[k]  = {bus[k].IF_RVALID, bus[k].IF_RDATA, bus[k].LS_RVALID, bus[k].LS_RDATA};
    always @(negedge CLK) if (RESET_N && run) mon(k, rsp_vec[k]);
  end

  // One clock of directed stimulus with its hand-specified winner.
  task automatic step(input logic ir, input logic [31:0] ia, input logic lr, input logic lw,
                      input logic [3:0] lbe, input logic [31:0] la, input logic [31:0] lwd,
                      input logic fl, input int exp_g);
    logic [71:0] e_port;
    exp_t        e;
    @(posedge CLK); #1;
    if_req = ir; if_addr = ia; ls_req = lr; ls_we = lw; ls_be = lbe;
    ls_addr = la; ls_wdata = lwd; flush = fl;
    if (rel_pending) begin
      RESET_N = 1'b1;
      rel_pending = 1'b0;
    end
    e_port = '0;
    if (exp_g == G_IF)      e_port = {1'b1, 1'b0, 1'b1, 1'b0, 4'hF, ia, 32'h0};
    else if (exp_g == G_LS) e_port = {1'b0, 1'b1, 1'b1, lw, lbe, la, lwd};
    if (fl) begin
      for (int k = 0; k < 3; k++) begin
        exp_t keep [$];
        keep = {};
        for (int i = 0; i < q[k].size(); i++)
          if (!(q[k][i].src && q[k][i].due > cyc)) keep.push_back(q[k][i]);
        q[k] = keep;
      end
    end
    if (exp_g == G_IF || (exp_g == G_LS && !lw)) begin
      for (int k = 0; k < 3; k++) begin
        e.src  = (exp_g == G_IF);
        e.due  = cyc + lat[k];
        e.data = mdata(cyc + lat[k]);
        q[k].push_back(e);
      end
    end
    @(negedge CLK);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (port_vec[k] !== e_port) begin
        failures++;
        $display("FAIL port lat=%0d cyc=%0d got=%h want=%h", lat[k], cyc, port_vec[k], e_port);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, G_NONE);
  endtask

  task automatic contend(input int n, input int first_if, input logic [31:0] base);
    for (int i = 0; i < n; i++)
      step(1'b1, base + 32'(i * 4), 1'b1, 1'b0, 4'hF, base + 32'h800 + 32'(i * 4), 32'h0,
           1'b0, ((i % 5) == first_if) ? G_IF : G_LS);
  endtask

  task automatic chk_zero(input string nm);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (port_vec[k] !== '0 || rsp_vec[k] !== '0) begin
        failures++;
        $display("FAIL %s lat=%0d got port=%h rsp=%h want all zero", nm, lat[k], port_vec[k], rsp_vec[k]);
      end
    end
  endtask

  initial begin
    #1 RESET_N = 1'b0;
    if_req = 1'b1; ls_req = 1'b1; if_addr = 32'h123; ls_addr = 32'h456;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk_zero("reset_state");
    @(posedge CLK); #1;
    if_req = 1'b0; ls_req = 1'b0; if_addr = '0; ls_addr = '0;
    RESET_N = 1'b1;
    run = 1'b1;

    // Fetch only
    step(1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, G_IF);
    idle(4);

    // Continuous contention: 4 LS, 1 IF, repeating
    contend(15, 4, 32'h1000);
    idle(4);

    // Store produces no response
    step(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h40, 32'hDEADBEEF, 1'b0, G_LS);
    idle(5);

    // Flush kills in-flight fetches, load survives, starve counter restarts
    step(1'b1, 32'h200, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, G_IF);
    step(1'b1, 32'h204, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, G_IF);
    step(1'b1, 32'h208, 1'b1, 1'b0, 4'hF, 32'h80, 32'h0, 1'b1, G_LS);
    contend(5, 4, 32'h3000);
    step(1'b1, 32'h300, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, G_NONE);
    idle(4);

    // Alternating load and fetch
    for (int i = 0; i < 6; i++) begin
      if ((i % 2) == 0) step(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h500 + 32'(i), 32'h0, 1'b0, G_LS);
      else              step(1'b1, 32'h600 + 32'(i), 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, G_IF);
    end
    idle(3);

    // Reset mid-flight after building starvation count of 2
    contend(2, 9, 32'h7000);
    #2;
    RESET_N = 1'b0;
    if_req = 1'b1; ls_req = 1'b1;
    for (int k = 0; k < 3; k++) q[k].delete();
    #1;
    chk_zero("reset_midflight");
    rel_pending = 1'b1;
    contend(5, 4, 32'h9000);
    idle(5);

    for (int k = 0; k < 3; k++) begin
      checks++;
      if (q[k].size() != 0) begin
        failures++;
        $display("FAIL drain lat=%0d got %0d pending want 0", lat[k], q[k].size());
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
